// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and widths for the handshaked sequential ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PASS_B = 4'b0000,
        OP_ADD    = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_AND    = 4'b0100,
        OP_OR     = 4'b0101,
        OP_XOR    = 4'b0110,
        OP_LSL    = 4'b1000,
        OP_LSR    = 4'b1001,
        OP_ASR    = 4'b1010,
        OP_MUL    = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: pass, add/sub, logic and shifts with per-op flags.
// MUL is handled by the sequential wrapper and is reported as illegal here.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0] shamt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign shamt = b[SHW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    // SUB as A + ~B + 1, so the carry out reads as "no borrow"
    assign diff  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_PASS_B: result = b;
            OP_ADD: begin
                result    = sum[MSB:0];
                carry_out = sum[WIDTH];
                overflow  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result    = diff[MSB:0];
                carry_out = diff[WIDTH];
                overflow  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LSL:  result = a << shamt;
            OP_LSR:  result = a >> shamt;
            OP_ASR:  result = WIDTH'($signed(a) >>> shamt);
            default: illegal = 1'b1;
        endcase
        negative = result[MSB];
        zero     = !illegal && (result == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: one-cycle ops via alu_comb_core, fixed-latency shift-add
// multiplier, registered per-op flags and an architectural NZVC register.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  op,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic             illegal
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;
    logic             set_flags_q, set_flags_d;
    logic [3:0]       nzvc_q, nzvc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW:0]     count_q, count_d;

    logic [WIDTH-1:0] core_result;
    logic             core_n, core_z, core_v, core_c, core_ill;
    logic             accept;

    alu_comb_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a         (A),
        .b         (B),
        .op        (op),
        .result    (core_result),
        .negative  (core_n),
        .zero      (core_z),
        .overflow  (core_v),
        .carry_out (core_c),
        .illegal   (core_ill)
    );

    // Gated by reset so nothing is offered to the source while held in reset
    assign in_ready = reset && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        negative_d  = negative_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        carry_d     = carry_q;
        illegal_d   = illegal_q;
        set_flags_d = set_flags_q;
        nzvc_d      = nzvc_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    set_flags_d = set_flags;
                    if (op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = A;
                        mplier_d = B;
                        count_d  = (SHW+1)'(WIDTH);
                        state_d  = MUL_BUSY;
                    end else begin
                        result_d   = core_result;
                        negative_d = core_n;
                        zero_d     = core_z;
                        overflow_d = core_v;
                        carry_d    = core_c;
                        illegal_d  = core_ill;
                        state_d    = DONE;
                    end
                end
            end
            MUL_BUSY: begin
                // Fixed WIDTH iterations, then one more cycle to publish the product
                if (count_q == '0) begin
                    result_d   = acc_q;
                    negative_d = acc_q[WIDTH-1];
                    zero_d     = (acc_q == '0);
                    overflow_d = 1'b0;
                    carry_d    = 1'b0;
                    illegal_d  = 1'b0;
                    state_d    = DONE;
                end else begin
                    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q - (SHW+1)'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (set_flags_q && !illegal_q)
                        nzvc_d = {negative_q, zero_q, overflow_q, carry_q};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
            set_flags_q <= 1'b0;
            nzvc_q      <= 4'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
            set_flags_q <= set_flags_d;
            nzvc_q      <= nzvc_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign negative  = negative_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_q;
    assign illegal   = illegal_q;
    assign flag_n    = nzvc_q[3];
    assign flag_z    = nzvc_q[2];
    assign flag_v    = nzvc_q[1];
    assign flag_c    = nzvc_q[0];

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 64-bit instance for the single-cycle ops,
// backpressure and reset abort, and an 8-bit instance for multiplier latency.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        in_valid64, in_ready64, out_valid64, out_ready64, sf64;
    logic [3:0]  op64;
    logic [63:0] a64, b64, result64;
    logic        n64, z64, v64, c64, fn64, fz64, fv64, fc64, ill64;

    // 8-bit instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8, sf8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        n8, z8, v8, c8, fn8, fz8, fv8, fc8, ill8;

    seq_alu #(.WIDTH(64)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .A(a64), .B(b64), .op(op64), .set_flags(sf64),
        .out_valid(out_valid64), .out_ready(out_ready64), .result(result64),
        .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64),
        .flag_n(fn64), .flag_z(fz64), .flag_v(fv64), .flag_c(fc64), .illegal(ill64)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .op(op8), .set_flags(sf8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8),
        .flag_n(fn8), .flag_z(fz8), .flag_v(fv8), .flag_c(fc8), .illegal(ill8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        sf;
        logic [63:0] res;
        logic [3:0]  flags;   // expected {N,Z,V,C} of this result
        logic        ill;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_nzvc64 = 4'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One single-cycle op on the 64-bit instance with immediate consumption
    task automatic run64(input vec_t v);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready64), 64'd1);
        a64 = v.a; b64 = v.b; op64 = v.op; sf64 = v.sf;
        in_valid64 = 1'b1; out_ready64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        chk("out_valid_lat1", 64'(out_valid64), 64'd1);
        chk("result", result64, v.res);
        chk("flags_nzvc", 64'({n64, z64, v64, c64}), 64'(v.flags));
        chk("illegal", 64'(ill64), 64'(v.ill));
        if (v.sf && !v.ill) exp_nzvc64 = v.flags;
        @(posedge clk); #1;
        chk("out_valid_drop", 64'(out_valid64), 64'd0);
        chk("arch_nzvc", 64'({fn64, fz64, fv64, fc64}), 64'(exp_nzvc64));
        $display("txn64 op=%b a=%h b=%h sf=%0b result=%h flags=%b ill=%0b nzvc=%b",
                 v.op, v.a, v.b, v.sf, result64, {n64, z64, v64, c64}, ill64,
                 {fn64, fz64, fv64, fc64});
    endtask

    // 8-bit multiply: checks fixed WIDTH+1 latency and in_ready low throughout
    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; op8 = OP_MUL; sf8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            chk("mul_in_ready", 64'(in_ready8), 64'd0);
            chk("mul_out_valid", 64'(out_valid8), 64'(k == 9));
        end
        chk("mul_result", 64'(result8), 64'(exp));
        chk("mul_flags", 64'({n8, z8, v8, c8}), 64'({exp[7], exp == 8'd0, 2'b00}));
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("mul_done_drop", 64'(out_valid8), 64'd0);
        chk("mul_nzvc", 64'({fn8, fz8, fv8, fc8}), 64'({exp[7], exp == 8'd0, 2'b00}));
        $display("txn8 MUL a=%0d b=%0d result=%h nzvc=%b", a, b, result8, {fn8, fz8, fv8, fc8});
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1010, 1'b0};
        vecs[1]  = '{OP_SUB,    64'd5, 64'd5, 1'b0, 64'd0, 4'b0101, 1'b0};
        vecs[2]  = '{OP_ASR,    64'h8000_0000_0000_0010, 64'h104, 1'b0, 64'hF800_0000_0000_0001, 4'b1000, 1'b0};
        vecs[3]  = '{OP_LSL,    64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 4'b0000, 1'b0};
        vecs[4]  = '{OP_ADD,    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 4'b0101, 1'b0};
        vecs[5]  = '{OP_SUB,    64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        vecs[6]  = '{OP_SUB,    64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0};
        vecs[7]  = '{OP_AND,    64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 4'b1000, 1'b0};
        vecs[8]  = '{OP_OR,     64'd0, 64'd0, 1'b0, 64'd0, 4'b0100, 1'b0};
        vecs[9]  = '{OP_XOR,    64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        vecs[10] = '{OP_LSR,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF3F, 1'b0, 64'd1, 4'b0000, 1'b0};
        vecs[11] = '{OP_LSL,    64'd1, 64'h43, 1'b0, 64'd8, 4'b0000, 1'b0};
        vecs[12] = '{OP_PASS_B, 64'hDEAD, 64'h1234, 1'b1, 64'h1234, 4'b0000, 1'b0};
        vecs[13] = '{4'b0001,   64'd5, 64'd3, 1'b1, 64'd0, 4'b0000, 1'b1};

        reset = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; sf64 = 1'b0; op64 = 4'b0; a64 = '0; b64 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; sf8 = 1'b0; op8 = 4'b0; a8 = '0; b8 = '0;
        #12;
        chk("rst_result", result64, 64'd0);
        chk("rst_out_valid", 64'(out_valid64), 64'd0);
        chk("rst_nzvc", 64'({fn64, fz64, fv64, fc64, ill64}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready64), 64'd1);

        for (int i = 0; i < NVEC; i++) run64(vecs[i]);

        mul8(8'd13, 8'd11, 8'h8F);
        mul8(8'd200, 8'd3, 8'h58);
        mul8(8'd0, 8'd77, 8'h00);

        // Backpressure: XOR result must hold while out_ready is low
        @(negedge clk);
        a64 = 64'hFF00_FF00_FF00_FF00; b64 = 64'h0F0F_0F0F_0F0F_0F0F;
        op64 = OP_XOR; sf64 = 1'b1; in_valid64 = 1'b1; out_ready64 = 1'b0;
        @(posedge clk); #1;
        a64 = 64'd1; b64 = 64'd1; op64 = OP_ADD; sf64 = 1'b0;   // must be ignored while busy
        chk("bp_first_valid", 64'(out_valid64), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_result_hold", result64, 64'hF00F_F00F_F00F_F00F);
            chk("bp_flags_hold", 64'({n64, z64, v64, c64, out_valid64, in_ready64}), 64'b100010);
        end
        chk("bp_nzvc_unchanged", 64'({fn64, fz64, fv64, fc64}), 64'(exp_nzvc64));
        @(negedge clk);
        in_valid64 = 1'b0; out_ready64 = 1'b1;
        @(posedge clk); #1;
        exp_nzvc64 = 4'b1000;
        chk("bp_release", 64'({out_valid64, in_ready64}), 64'b01);
        chk("bp_nzvc", 64'({fn64, fz64, fv64, fc64}), 64'(exp_nzvc64));
        $display("txn64 XOR backpressure result=%h nzvc=%b", result64, {fn64, fz64, fv64, fc64});

        // Reset during cycle 3 of a 64-bit MUL
        @(negedge clk);
        a64 = 64'd3; b64 = 64'd5; op64 = OP_MUL; sf64 = 1'b1; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        exp_nzvc64 = 4'b0;
        chk("abort_result", result64, 64'd0);
        chk("abort_outputs", 64'({n64, z64, v64, c64, ill64, out_valid64, in_ready64}), 64'd0);
        chk("abort_nzvc", 64'({fn64, fz64, fv64, fc64}), 64'd0);
        chk("abort_nzvc8", 64'({fn8, fz8, fv8, fc8, out_valid8}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", 64'(in_ready64), 64'd1);
        @(posedge clk); #1;
        chk("abort_no_stale_valid", 64'(out_valid64), 64'd0);
        $display("txn64 MUL aborted by reset result=%h out_valid=%0b", result64, out_valid64);

        run64(vecs[0]);
        run64('{4'b1111, 64'h1234, 64'h5678, 1'b1, 64'd0, 4'b0000, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
